// File: rtl/gpioemu_arbiter.sv
// Round-robin arbiter sharing one gpioemu compute core between two requesters.
// Latches the winner's operands, starts the core, waits (with timeout) and returns the result.
module gpioemu_arbiter #(
  parameter int TIMEOUT = 200,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [47:0] a1_in,
  input  logic [47:0] a2_in,
  output logic [1:0]  ack,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic [1:0]  rsp_b,
  output logic        rsp_err,
  output logic [23:0] core_a1,
  output logic [23:0] core_a2,
  output logic        core_start,
  input  logic        core_ready,
  input  logic        core_valid,
  input  logic [31:0] core_w,
  input  logic [23:0] core_l,
  input  logic [1:0]  core_b,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic               rr, winner, grant_id;
  logic [TW-1:0]      timer;
  logic [1:0][23:0]   a1_lane, a2_lane;
  logic               timeout_hit, rsp_take;

  assign a1_lane = a1_in;
  assign a2_lane = a2_in;

  // rr names the requester that has priority in the next IDLE grant
  assign winner      = req[rr] ? rr : ~rr;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign rsp_take    = rsp_ready[grant_id];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)                      state_nxt = ISSUE;
      ISSUE:   if (core_ready)                state_nxt = WAIT;
      WAIT:    if (core_valid || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_take)                  state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack        <= '0;
      rsp_valid  <= '0;
      rsp_w      <= '0;
      rsp_l      <= '0;
      rsp_b      <= '0;
      rsp_err    <= 1'b0;
      core_a1    <= '0;
      core_a2    <= '0;
      core_start <= 1'b0;
      rr         <= 1'b0;
      grant_id   <= 1'b0;
      timer      <= '0;
    end else begin
      ack        <= '0;
      core_start <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          ack      <= 2'(1) << winner;
          grant_id <= winner;
          rr       <= ~winner;
          core_a1  <= a1_lane[winner];
          core_a2  <= a2_lane[winner];
        end
        ISSUE: if (core_ready) begin
          core_start <= 1'b1;
          timer      <= '0;
        end
        // a result arriving on the expiry cycle still wins over the timeout
        WAIT: if (core_valid) begin
          rsp_w     <= core_w;
          rsp_l     <= core_l;
          rsp_b     <= core_b;
          rsp_err   <= 1'b0;
          rsp_valid <= 2'(1) << grant_id;
        end else if (timeout_hit) begin
          rsp_w     <= '0;
          rsp_l     <= '0;
          rsp_b     <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= 2'(1) << grant_id;
        end else begin
          timer <= timer + 1'b1;
        end
        RESP: if (rsp_take) rsp_valid <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpioemu_arbiter.sv
// Directed bench for gpioemu_arbiter: one task per scenario, inline checks.
module tb_gpioemu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, ack, rsp_valid, rsp_ready, rsp_b, core_b;
  logic [47:0] a1_in, a2_in;
  logic [31:0] rsp_w, core_w;
  logic [23:0] rsp_l, core_l, core_a1, core_a2;
  logic        rsp_err, core_start, core_ready, core_valid, busy;

  int checks = 0;
  int errors = 0;

  gpioemu_arbiter #(.TIMEOUT(200), .TW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .a1_in(a1_in), .a2_in(a2_in), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_l(rsp_l),
    .rsp_b(rsp_b), .rsp_err(rsp_err), .core_a1(core_a1), .core_a2(core_a2),
    .core_start(core_start), .core_ready(core_ready), .core_valid(core_valid),
    .core_w(core_w), .core_l(core_l), .core_b(core_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // wait (bounded) for core_start, then answer with one core_valid pulse
  task automatic run_core(input logic [31:0] w, input logic [23:0] l, input logic [1:0] b,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (core_start === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      core_valid = 1'b1; core_w = w; core_l = l; core_b = b;
      tick();
      core_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; a1_in = '0; a2_in = '0; rsp_ready = '0;
    core_ready = 1'b1; core_valid = 1'b0; core_w = '0; core_l = '0; core_b = '0;
    tick(); tick();
    checks++;
    if ({ack, rsp_valid, rsp_w, rsp_l, rsp_b, rsp_err, core_a1, core_a2, core_start, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b rsp_valid=%b w=%h l=%h b=%b err=%b a1=%h a2=%h start=%b busy=%b exp all 0",
               ack, rsp_valid, rsp_w, rsp_l, rsp_b, rsp_err, core_a1, core_a2, core_start, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int bad = 0;
    req = 2'b01; a1_in = {24'hffffff, 24'h123456}; a2_in = {24'heeeeee, 24'h789abc};
    tick();
    checks++;
    if (ack !== 2'b01 || core_a1 !== 24'h123456 || core_a2 !== 24'h789abc || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack ack=%b a1=%h a2=%h busy=%b exp 01 123456 789abc 1", ack, core_a1, core_a2, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if (ack !== 2'b00 || core_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start ack=%b start=%b exp 00 1", ack, core_start);
    end
    for (int i = 0; i < 29; i++) begin
      tick();
      if (core_start !== 1'b0 || rsp_valid !== 2'b00 || ack !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wait_quiet bad_cycles=%0d exp 0", bad);
    end
    core_valid = 1'b1; core_w = 32'h0000_0010; core_l = 24'h000005; core_b = 2'b01;
    tick();
    core_valid = 1'b0; core_w = '0; core_l = '0; core_b = '0;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_w !== 32'h10 || rsp_l !== 24'h5 || rsp_b !== 2'b01 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp valid=%b w=%h l=%h b=%b err=%b exp 01 00000010 000005 01 0",
               rsp_valid, rsp_w, rsp_l, rsp_b, rsp_err);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_w !== 32'h10) begin
      errors++;
      $display("FAIL single_done valid=%b busy=%b w=%h exp 00 0 00000010", rsp_valid, busy, rsp_w);
    end
  endtask

  // rr was left at 1 by the previous grant; reset must bring requester 0 back to priority
  task automatic test_round_robin();
    logic [1:0] exp_id [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    bit ok;
    reset = 1'b1; req = 2'b11; rsp_ready = 2'b11;
    a1_in = {24'h111111, 24'h000000};
    tick();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (ack !== exp_id[t]) begin
        errors++;
        $display("FAIL rr_ack_%0d ack=%b exp %b", t, ack, exp_id[t]);
      end
      run_core(32'(t), 24'(t), 2'b00, ok);
      checks++;
      if (!ok || rsp_valid !== exp_id[t]) begin
        errors++;
        $display("FAIL rr_rsp_%0d started=%0d valid=%b exp 1 %b", t, ok, rsp_valid, exp_id[t]);
      end
      tick();
    end
    req = 2'b00;
    tick(); tick(); tick();
    rsp_ready = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain busy=%b exp 0", busy);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    req = 2'b01; core_w = 32'hdeadbeef; core_l = 24'hcafe01; core_b = 2'b11;
    tick();
    req = 2'b00;
    tick();
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start start=%b exp 1", core_start);
    end
    for (k = 1; k <= 250; k++) begin
      tick();
      if (rsp_valid !== 2'b00) break;
    end
    checks++;
    if (k != 200 || rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_w !== '0 || rsp_l !== '0 || rsp_b !== '0) begin
      errors++;
      $display("FAIL to_rsp cycles=%0d valid=%b err=%b w=%h l=%h b=%b exp 200 01 1 0 0 0",
               k, rsp_valid, rsp_err, rsp_w, rsp_l, rsp_b);
    end
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_w !== '0) begin
      errors++;
      $display("FAIL to_late_resp valid=%b err=%b w=%h exp 01 1 0", rsp_valid, rsp_err, rsp_w);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_err !== 1'b1 || rsp_w !== '0) begin
      errors++;
      $display("FAIL to_late_idle busy=%b valid=%b err=%b w=%h exp 0 00 1 0", busy, rsp_valid, rsp_err, rsp_w);
    end
  endtask

  // core_valid lands exactly on the expiry edge: result wins
  task automatic test_timeout_edge();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    for (int i = 0; i < 199; i++) tick();
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL edge_early valid=%b exp 00", rsp_valid);
    end
    core_valid = 1'b1; core_w = 32'h55aa55aa; core_l = 24'h0a0b0c; core_b = 2'b10;
    tick();
    core_valid = 1'b0;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_w !== 32'h55aa55aa || rsp_l !== 24'h0a0b0c || rsp_b !== 2'b10) begin
      errors++;
      $display("FAIL edge_rsp valid=%b err=%b w=%h l=%h b=%b exp 01 0 55aa55aa 0a0b0c 10",
               rsp_valid, rsp_err, rsp_w, rsp_l, rsp_b);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_rsp_stall();
    bit ok;
    int bad = 0;
    req = 2'b01; a1_in = {24'h222222, 24'h333333};
    tick();
    req = 2'b10;
    run_core(32'h0badcafe, 24'h123123, 2'b01, ok);
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 2'b01 || rsp_w !== 32'h0badcafe || rsp_l !== 24'h123123 || ack !== 2'b00) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL stall_hold started=%0d bad_cycles=%0d exp 1 0", ok, bad);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00 || ack !== 2'b00) begin
      errors++;
      $display("FAIL stall_release valid=%b ack=%b exp 00 00", rsp_valid, ack);
    end
    tick();
    checks++;
    if (ack !== 2'b10 || core_a1 !== 24'h222222) begin
      errors++;
      $display("FAIL stall_next_ack ack=%b a1=%h exp 10 222222", ack, core_a1);
    end
    req = 2'b00; rsp_ready = 2'b10;
    run_core(32'h1, 24'h2, 2'b11, ok);
    checks++;
    if (!ok || rsp_valid !== 2'b10 || rsp_b !== 2'b11) begin
      errors++;
      $display("FAIL stall_next_rsp started=%0d valid=%b b=%b exp 1 10 11", ok, rsp_valid, rsp_b);
    end
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_core_not_ready();
    int bad = 0;
    req = 2'b01; a1_in = {24'h0, 24'habcdef}; core_ready = 1'b0;
    tick();
    req = 2'b00;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (core_start !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nready_hold bad_cycles=%0d exp 0", bad);
    end
    core_ready = 1'b1;
    tick();
    checks++;
    if (core_start !== 1'b1 || core_a1 !== 24'habcdef) begin
      errors++;
      $display("FAIL nready_start start=%b a1=%h exp 1 abcdef", core_start, core_a1);
    end
    core_valid = 1'b1; core_w = 32'h87654321; core_l = 24'h00ff00; core_b = 2'b01;
    tick();
    core_valid = 1'b0;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_w !== 32'h87654321 || rsp_l !== 24'h00ff00) begin
      errors++;
      $display("FAIL nready_rsp valid=%b err=%b w=%h l=%h exp 01 0 87654321 00ff00",
               rsp_valid, rsp_err, rsp_w, rsp_l);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok;
    req = 2'b01; a1_in = {24'h0, 24'h999999};
    tick();
    req = 2'b00;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack, rsp_valid, rsp_w, rsp_l, rsp_b, rsp_err, core_a1, core_a2, core_start, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs start=%b busy=%b a1=%h w=%h valid=%b exp all 0",
               core_start, busy, core_a1, rsp_w, rsp_valid);
    end
    tick();
    reset = 1'b0; req = 2'b10; a1_in = {24'h777777, 24'h0};
    tick();
    checks++;
    if (ack !== 2'b10 || core_a1 !== 24'h777777) begin
      errors++;
      $display("FAIL midreset_ack ack=%b a1=%h exp 10 777777", ack, core_a1);
    end
    req = 2'b00; rsp_ready = 2'b10;
    run_core(32'h42, 24'h43, 2'b10, ok);
    checks++;
    if (!ok || rsp_valid !== 2'b10 || rsp_w !== 32'h42) begin
      errors++;
      $display("FAIL midreset_rsp started=%0d valid=%b w=%h exp 1 10 00000042", ok, rsp_valid, rsp_w);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_timeout_edge();
    test_rsp_stall();
    test_core_not_ready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
